// File: rtl/path_dram_scheduler.sv
// Path ORAM DRAM command sequencer: reads every burst of a path root-to-leaf,
// then writes them back in the same order, gated by read-buffer credits and write-data beats.
module path_dram_scheduler #(
  parameter int ORAML     = 10,
  parameter int BktBursts = 4,
  parameter int DDRAWidth = 28,
  parameter int AddrShift = 3,
  parameter int BufDepth  = 44
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [ORAML-1:0]             ReqLeaf_i,
  input  logic [1:0]                   ReqOp_i,
  input  logic                         ReqValid_i,
  output logic                         ReqReady_o,
  output logic                         Done_o,
  output logic [DDRAWidth-1:0]         DRAMAddress_o,
  output logic [2:0]                   DRAMCommand_o,
  output logic                         DRAMCommandValid_o,
  input  logic                         DRAMCommandReady_i,
  input  logic                         BufDrain_i,
  input  logic                         WrBeat_i,
  output logic [$clog2(BufDepth+1)-1:0] Credits_o,
  output logic                         Error_o
);

  localparam int CW = $clog2(BufDepth + 1);
  localparam int LW = (ORAML > 0) ? $clog2(ORAML + 1) : 1;
  localparam int BW = (BktBursts > 1) ? $clog2(BktBursts) : 1;

  typedef enum logic [1:0] {IDLE, RD, WR} state_e;

  state_e                 state_q, state_d;
  logic [ORAML-1:0]       leaf_q, leaf_d;
  logic                   wrAfter_q, wrAfter_d;
  logic [LW-1:0]          lvl_q, lvl_d;
  logic [BW-1:0]          bst_q, bst_d;
  logic [CW-1:0]          credits_q, credits_d;
  logic [CW-1:0]          wrAhead_q, wrAhead_d;
  logic                   valid_q, valid_d;
  logic [DDRAWidth-1:0]   addr_q, addr_d;
  logic [2:0]             cmd_q, cmd_d;
  logic                   done_q, done_d;
  logic                   error_q, error_d;

  logic hs, rdHs, wrHs, lastBurst;

  function automatic logic [DDRAWidth-1:0] burstAddr(input logic [ORAML-1:0] leaf,
                                                     input logic [LW-1:0] lvl,
                                                     input logic [BW-1:0] bst);
    logic [63:0] node;
    node = ((64'd1 << lvl) - 64'd1) + (64'(leaf) >> (ORAML - int'(lvl)));
    return DDRAWidth'((node * 64'(BktBursts) + 64'(bst)) << AddrShift);
  endfunction

  assign hs        = valid_q && DRAMCommandReady_i;
  assign rdHs      = hs && (state_q == RD);
  assign wrHs      = hs && (state_q == WR);
  assign lastBurst = (lvl_q == LW'(ORAML)) && (bst_q == BW'(BktBursts - 1));

  always_comb begin
    state_d   = state_q;
    leaf_d    = leaf_q;
    wrAfter_d = wrAfter_q;
    lvl_d     = lvl_q;
    bst_d     = bst_q;
    credits_d = credits_q;
    wrAhead_d = wrAhead_q;
    addr_d    = addr_q;
    cmd_d     = cmd_q;
    done_d    = 1'b0;
    error_d   = error_q;
    valid_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (ReqValid_i) begin
          if (ReqOp_i == 2'b00) begin
            error_d = 1'b1;
          end else begin
            leaf_d    = ReqLeaf_i;
            wrAfter_d = ReqOp_i[1];
            lvl_d     = '0;
            bst_d     = '0;
            state_d   = ReqOp_i[0] ? RD : WR;
          end
        end
      end
      RD, WR: begin
        if (hs) begin
          if (lastBurst) begin
            lvl_d = '0;
            bst_d = '0;
            if (state_q == RD && wrAfter_q) begin
              state_d = WR;
            end else begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end else if (bst_q == BW'(BktBursts - 1)) begin
            bst_d = '0;
            lvl_d = lvl_q + LW'(1);
          end else begin
            bst_d = bst_q + BW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A drain with no matching read while the buffer is already empty is a protocol violation.
    if (rdHs && !BufDrain_i) begin
      credits_d = credits_q - CW'(1);
    end else if (BufDrain_i && !rdHs) begin
      if (credits_q == CW'(BufDepth)) error_d = 1'b1;
      else                            credits_d = credits_q + CW'(1);
    end

    if (wrHs && !WrBeat_i) begin
      wrAhead_d = wrAhead_q - CW'(1);
    end else if (WrBeat_i && !wrHs) begin
      if (wrAhead_q == CW'(BufDepth)) error_d = 1'b1;
      else                            wrAhead_d = wrAhead_q + CW'(1);
    end

    // Outputs are registered from next-state values so Valid tracks the gating counters exactly.
    valid_d = ((state_d == RD) && (credits_d != '0)) || ((state_d == WR) && (wrAhead_d != '0));
    if (state_d != IDLE) begin
      addr_d = burstAddr(leaf_d, lvl_d, bst_d);
      cmd_d  = (state_d == WR) ? 3'b000 : 3'b001;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      leaf_q    <= '0;
      wrAfter_q <= 1'b0;
      lvl_q     <= '0;
      bst_q     <= '0;
      credits_q <= CW'(BufDepth);
      wrAhead_q <= '0;
      valid_q   <= 1'b0;
      addr_q    <= '0;
      cmd_q     <= 3'b001;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      leaf_q    <= leaf_d;
      wrAfter_q <= wrAfter_d;
      lvl_q     <= lvl_d;
      bst_q     <= bst_d;
      credits_q <= credits_d;
      wrAhead_q <= wrAhead_d;
      valid_q   <= valid_d;
      addr_q    <= addr_d;
      cmd_q     <= cmd_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  assign ReqReady_o         = (state_q == IDLE);
  assign Done_o             = done_q;
  assign DRAMAddress_o      = addr_q;
  assign DRAMCommand_o      = cmd_q;
  assign DRAMCommandValid_o = valid_q;
  assign Credits_o          = credits_q;
  assign Error_o            = error_q;

endmodule

// File: tb/tb_path_dram_scheduler.sv
// Bench for path_dram_scheduler: queue-based command model checked every cycle,
// plus literal address sequences and directed corner cases.
module tb_path_dram_scheduler;

  localparam int ORAML = 2;
  localparam int BKT   = 2;
  localparam int AW    = 28;
  localparam int SH    = 3;
  localparam int DEPTH = 6;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [ORAML-1:0] ReqLeaf = '0;
  logic [1:0]       ReqOp = 2'b00;
  logic             ReqValid = 1'b0;
  logic             ReqReady_o;
  logic             Done_o;
  logic [AW-1:0]    DRAMAddress_o;
  logic [2:0]       DRAMCommand_o;
  logic             DRAMCommandValid_o;
  logic             DRAMCommandReady = 1'b1;
  logic             BufDrain = 1'b0;
  logic             WrBeat = 1'b0;
  logic [CW-1:0]    Credits_o;
  logic             Error_o;

  int nVec = 0;
  int nMis = 0;
  int drainMode = 0;
  int cyc = 0;

  typedef struct {int unsigned addr; bit isWr;} cmd_t;
  cmd_t        expQ[$];
  int unsigned obsAddr[$];
  bit          obsWr[$];
  int          mCred, mWr;
  bit          mErr, mBusy, mDone;

  path_dram_scheduler #(
    .ORAML(ORAML), .BktBursts(BKT), .DDRAWidth(AW), .AddrShift(SH), .BufDepth(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .ReqLeaf_i(ReqLeaf), .ReqOp_i(ReqOp), .ReqValid_i(ReqValid), .ReqReady_o(ReqReady_o),
    .Done_o(Done_o), .DRAMAddress_o(DRAMAddress_o), .DRAMCommand_o(DRAMCommand_o),
    .DRAMCommandValid_o(DRAMCommandValid_o), .DRAMCommandReady_i(DRAMCommandReady),
    .BufDrain_i(BufDrain), .WrBeat_i(WrBeat), .Credits_o(Credits_o), .Error_o(Error_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("[TB] FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned modelAddr(input int leaf, input int lvl, input int bst);
    int node;
    node = (1 << lvl) - 1 + (leaf >> (ORAML - lvl));
    return int'((node * BKT + bst) << SH);
  endfunction

  task automatic resetModel();
    expQ.delete();
    mCred = DEPTH;
    mWr   = 0;
    mErr  = 0;
    mBusy = 0;
    mDone = 0;
  endtask

  // Outputs are compared mid-cycle; the model then advances using the inputs the next edge will see.
  initial begin
    resetModel();
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        resetModel();
        checkOutput("rstAddr", 32'(DRAMAddress_o), 0);
        checkOutput("rstCmd", 32'(DRAMCommand_o), 1);
        checkOutput("rstValid", 32'(DRAMCommandValid_o), 0);
        checkOutput("rstReady", 32'(ReqReady_o), 1);
        checkOutput("rstDone", 32'(Done_o), 0);
        checkOutput("rstCredits", 32'(Credits_o), DEPTH);
        checkOutput("rstError", 32'(Error_o), 0);
      end else begin
        bit expValid, headWr, hs, rdHs, wrHs, wasBusy, doneNext;
        headWr   = mBusy ? expQ[0].isWr : 1'b0;
        expValid = mBusy && (headWr ? (mWr != 0) : (mCred != 0));
        checkOutput("ReqReady", 32'(ReqReady_o), 32'(!mBusy));
        checkOutput("Done", 32'(Done_o), 32'(mDone));
        checkOutput("Valid", 32'(DRAMCommandValid_o), 32'(expValid));
        checkOutput("Credits", 32'(Credits_o), 32'(mCred));
        checkOutput("Error", 32'(Error_o), 32'(mErr));
        if (expValid) begin
          checkOutput("Address", 32'(DRAMAddress_o), expQ[0].addr);
          checkOutput("Command", 32'(DRAMCommand_o), headWr ? 32'd0 : 32'd1);
        end

        wasBusy  = mBusy;
        hs       = expValid && DRAMCommandReady;
        rdHs     = hs && !headWr;
        wrHs     = hs && headWr;
        doneNext = 0;
        if (hs) begin
          obsAddr.push_back(32'(DRAMAddress_o));
          obsWr.push_back(DRAMCommand_o == 3'b000);
          void'(expQ.pop_front());
          if (expQ.size() == 0) begin
            mBusy    = 0;
            doneNext = 1;
          end
        end
        if (!wasBusy && ReqValid) begin
          if (ReqOp == 2'b00) begin
            mErr = 1;
          end else begin
            for (int p = 0; p < 2; p++)
              if (ReqOp[p])
                for (int l = 0; l <= ORAML; l++)
                  for (int b = 0; b < BKT; b++)
                    expQ.push_back('{modelAddr(int'(ReqLeaf), l, b), p == 1});
            mBusy = 1;
          end
        end
        if (rdHs && !BufDrain) mCred--;
        else if (BufDrain && !rdHs) begin
          if (mCred == DEPTH) mErr = 1;
          else mCred++;
        end
        if (WrBeat && !wrHs) begin
          if (mWr == DEPTH) mErr = 1;
          else mWr++;
        end else if (wrHs && !WrBeat) mWr--;
        mDone = doneNext;
      end
    end
  end

  // Drain driver: 1 = pulse every third cycle, 2 = refill to full, 3 = drain regardless of level.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      cyc++;
      BufDrain = 1'b0;
      case (drainMode)
        1: BufDrain = (cyc % 3 == 0) && (Credits_o != CW'(DEPTH));
        2: BufDrain = (Credits_o != CW'(DEPTH));
        3: BufDrain = 1'b1;
        default: BufDrain = 1'b0;
      endcase
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [ORAML-1:0] leaf, input logic [1:0] op);
    int n = 0;
    while (!ReqReady_o && n < 200) begin tick(1); n++; end
    checkOutput("reqReadyWait", 32'(ReqReady_o), 1);
    ReqLeaf  = leaf;
    ReqOp    = op;
    ReqValid = 1'b1;
    tick(1);
    ReqValid = 1'b0;
  endtask

  task automatic waitDone(input string name);
    int n = 0;
    while (!Done_o && n < 200) begin tick(1); n++; end
    checkOutput(name, 32'(Done_o), 1);
  endtask

  task automatic refill();
    int n = 0;
    drainMode = 2;
    while (Credits_o != CW'(DEPTH) && n < 50) begin tick(1); n++; end
    drainMode = 0;
    tick(1);
    checkOutput("refill", 32'(Credits_o), DEPTH);
  endtask

  task automatic checkSeq(input string name, input int base, input int unsigned e[6], input bit wr);
    checkOutput({name, "Count"}, 32'(obsAddr.size() >= base + 6), 1);
    for (int i = 0; i < 6; i++)
      if (base + i < obsAddr.size()) begin
        checkOutput({name, "Addr"}, obsAddr[base+i], e[i]);
        checkOutput({name, "Wr"}, 32'(obsWr[base+i]), 32'(wr));
      end
  endtask

  initial begin
    int unsigned leaf2[6] = '{0, 8, 32, 40, 80, 88};
    int unsigned leaf1[6] = '{0, 8, 16, 24, 64, 72};
    int unsigned leaf3[6] = '{0, 8, 32, 40, 96, 104};
    int base;
    int unsigned holdAddr;

    tick(3);
    rst_n = 1'b1;
    tick(2);

    $display("[TB] read-only path, leaf 2");
    base = obsAddr.size();
    applyStimulus(2'b10, 2'b01);
    waitDone("doneRd");
    checkSeq("rdOnly", base, leaf2, 1'b0);
    checkOutput("creditsEmpty", 32'(Credits_o), 0);

    $display("[TB] read-only path throttled by credits");
    base = obsAddr.size();
    drainMode = 1;
    applyStimulus(2'b10, 2'b01);
    waitDone("doneThrottle");
    drainMode = 0;
    checkSeq("throttle", base, leaf2, 1'b0);
    refill();

    $display("[TB] read then write path");
    base = obsAddr.size();
    applyStimulus(2'b10, 2'b11);
    WrBeat = 1'b1;
    tick(6);
    WrBeat = 1'b0;
    waitDone("doneRdWr");
    checkSeq("rwRead", base, leaf2, 1'b0);
    checkSeq("rwWrite", base + 6, leaf2, 1'b1);
    refill();

    $display("[TB] write-only path gated by write beats");
    base = obsAddr.size();
    applyStimulus(2'b01, 2'b10);
    tick(5);
    checkOutput("noBeatValid", 32'(DRAMCommandValid_o), 0);
    WrBeat = 1'b1;
    tick(1);
    WrBeat = 1'b0;
    tick(3);
    checkOutput("oneWrite", 32'(obsAddr.size()), 32'(base + 1));
    checkOutput("oneWriteAddr", (obsAddr.size() > base) ? obsAddr[base] : 32'hFFFF_FFFF, 0);
    checkOutput("validDropped", 32'(DRAMCommandValid_o), 0);
    WrBeat = 1'b1;
    tick(5);
    WrBeat = 1'b0;
    waitDone("doneWrOnly");
    checkSeq("wrOnly", base, leaf1, 1'b1);

    $display("[TB] command ready stall mid-stream");
    base = obsAddr.size();
    applyStimulus(2'b11, 2'b01);
    tick(2);
    DRAMCommandReady = 1'b0;
    holdAddr = 32'(DRAMAddress_o);
    checkOutput("stallAddr", holdAddr, 32);
    for (int i = 0; i < 5; i++) begin
      tick(1);
      checkOutput("stallHoldAddr", 32'(DRAMAddress_o), holdAddr);
      checkOutput("stallHoldValid", 32'(DRAMCommandValid_o), 1);
    end
    DRAMCommandReady = 1'b1;
    waitDone("doneStall");
    checkSeq("stall", base, leaf3, 1'b0);
    refill();

    $display("[TB] reset mid-read");
    applyStimulus(2'b10, 2'b11);
    tick(3);
    rst_n = 1'b0;
    #1;
    checkOutput("abortCredits", 32'(Credits_o), DEPTH);
    checkOutput("abortValid", 32'(DRAMCommandValid_o), 0);
    checkOutput("abortReady", 32'(ReqReady_o), 1);
    tick(2);
    rst_n = 1'b1;
    tick(2);

    $display("[TB] error cases");
    drainMode = 3;
    tick(1);
    drainMode = 0;
    tick(2);
    checkOutput("drainFullErr", 32'(Error_o), 1);
    checkOutput("drainFullCredits", 32'(Credits_o), DEPTH);
    tick(5);
    checkOutput("errSticky", 32'(Error_o), 1);
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    checkOutput("errCleared", 32'(Error_o), 0);
    applyStimulus(2'b10, 2'b00);
    tick(1);
    checkOutput("badOpErr", 32'(Error_o), 1);
    checkOutput("badOpIdle", 32'(ReqReady_o), 1);
    checkOutput("badOpNoCmd", 32'(DRAMCommandValid_o), 0);
    tick(3);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
